ram_arbiter: RTL

Round-robin arbiter that shares one single-port block RAM among `NREQ` requesters (CPU, DMA, video fetch), issuing at most one access per clock. It sits directly in front of a `singleport_ram` (registered output, `RD_LAT=2`) or a `singleport_unreg_ram` (`RD_LAT=1`) and drives that RAM's address, data and write-enable pins. Read data is returned to the issuing requester with a per-requester valid strobe.

---
 rtl/ram_arbiter_if.sv | 25 ++
 rtl/ram_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the block-RAM arbiter.
// Addresses and data are packed per requester: slot i at [i*w +: w].
interface ram_arbiter_if #(
    parameter int width   = 8,
    parameter int widthad = 10,
    parameter int NREQ    = 3
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         we;
    logic [NREQ*widthad-1:0] addr;
    logic [NREQ*width-1:0]   wdata;
    logic [NREQ-1:0]         ack;
    logic [NREQ-1:0]         rvalid;
    logic [width-1:0]        rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rvalid, rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM among NREQ requesters.
// One access per clock; read data is routed back through a tag pipeline.
module ram_arbiter #(
    parameter int width   = 8,
    parameter int widthad = 10,
    parameter int NREQ    = 3,
    parameter int RD_LAT  = 2
) (
    input  logic               clock,
    input  logic               reset,
    ram_arbiter_if.slave       bus,
    output logic [widthad-1:0] ram_address,
    output logic [width-1:0]   ram_data,
    output logic               ram_wren,
    input  logic [width-1:0]   ram_q
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          found;

    // Tag slot s is visible s cycles after the issue edge; ram_q lines up
    // with slot RD_LAT because the RAM captures our registered address.
    logic [RD_LAT:0] tag_v;
    logic [IW-1:0]   tag_i [RD_LAT+1];

    always_comb begin
        found = 1'b0;
        win   = last;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last        <= IW'(NREQ - 1);
            bus.ack     <= '0;
            ram_wren    <= 1'b0;
            ram_address <= '0;
            ram_data    <= '0;
            tag_v       <= '0;
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_i[s] <= '0;
            end
        end else begin
            bus.ack  <= '0;
            ram_wren <= 1'b0;
            tag_v    <= {tag_v[RD_LAT-1:0], found && !bus.we[win]};
            tag_i[0] <= win;
            for (int s = 1; s <= RD_LAT; s++) begin
                tag_i[s] <= tag_i[s-1];
            end
            if (found) begin
                last         <= win;
                bus.ack[win] <= 1'b1;
                ram_address  <= bus.addr[int'(win)*widthad +: widthad];
                ram_data     <= bus.wdata[int'(win)*width +: width];
                ram_wren     <= bus.we[win];
            end
        end
    end

    always_comb begin
        bus.rvalid = '0;
        if (tag_v[RD_LAT]) begin
            bus.rvalid[tag_i[RD_LAT]] = 1'b1;
        end
    end

    assign bus.rdata = ram_q;
endmodule
